// File: rtl/aq_axi_sdma64_sync_fifo.sv
// Single-clock FIFO with sticky overflow/underflow flags and programmable almost-full/empty.
// Define AQ_AXI_SDMA64_SYNC_FIFO_FWFT_EN to add a first-word-fall-through output stage.
module aq_axi_sdma64_sync_fifo #(
  parameter int FIFO_DEPTH = 9,
  parameter int FIFO_WIDTH = 65
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  FIFO_CLEAR,
  input  logic                  FIFO_WR_ENA,
  input  logic [FIFO_WIDTH-1:0] FIFO_WR_DATA,
  output logic                  FIFO_WR_FULL,
  output logic                  FIFO_WR_ALM_FULL,
  input  logic [FIFO_DEPTH:0]   FIFO_WR_ALM_COUNT,
  input  logic                  FIFO_RD_ENA,
  output logic [FIFO_WIDTH-1:0] FIFO_RD_DATA,
  output logic                  FIFO_RD_EMPTY,
  output logic                  FIFO_RD_ALM_EMPTY,
  input  logic [FIFO_DEPTH:0]   FIFO_RD_ALM_COUNT,
  output logic [FIFO_DEPTH:0]   FIFO_COUNT,
  output logic                  FIFO_OVERFLOW,
  output logic                  FIFO_UNDERFLOW
);

  localparam int D = 1 << FIFO_DEPTH;
  localparam int CW = FIFO_DEPTH + 1;
  localparam logic [CW-1:0] DEPTH_W = {1'b1, {FIFO_DEPTH{1'b0}}};

  logic [FIFO_WIDTH-1:0] mem_q [0:D-1];
  logic [FIFO_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [FIFO_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [CW-1:0]         alm_thr;
  logic                  full, empty, wr_acc, rd_acc, mem_pop;

  assign full    = (count_q == DEPTH_W);
  assign alm_thr = (DEPTH_W > FIFO_WR_ALM_COUNT) ? (DEPTH_W - FIFO_WR_ALM_COUNT) : '0;

`ifdef AQ_AXI_SDMA64_SYNC_FIFO_FWFT_EN
  logic          out_vld_q, out_vld_d;
  logic [CW-1:0] mem_cnt;

  // Output register holds one word that is still counted in FIFO_COUNT.
  assign mem_cnt = count_q - CW'(out_vld_q);
  assign empty   = ~out_vld_q;
  assign rd_acc  = FIFO_RD_ENA & ~empty & ~FIFO_CLEAR;
  assign mem_pop = (mem_cnt != '0) & (~out_vld_q | rd_acc) & ~FIFO_CLEAR;

  always_comb begin
    out_vld_d = out_vld_q;
    if (FIFO_CLEAR) out_vld_d = 1'b0;
    else            out_vld_d = mem_pop | (out_vld_q & ~rd_acc);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) out_vld_q <= 1'b0;
    else        out_vld_q <= out_vld_d;
  end
`else
  assign empty   = (count_q == '0);
  assign rd_acc  = FIFO_RD_ENA & ~empty & ~FIFO_CLEAR;
  assign mem_pop = rd_acc;
`endif

  assign wr_acc = FIFO_WR_ENA & ~full & ~FIFO_CLEAR;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    if (FIFO_CLEAR) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (mem_pop) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        rd_data_d = mem_q[rd_ptr_q];
      end
      // Space freed by a read is only visible to writers on the next edge.
      if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
      else if (!wr_acc && rd_acc) count_d = count_q - 1'b1;
      if (FIFO_WR_ENA && full)  ovf_d = 1'b1;
      if (FIFO_RD_ENA && empty) unf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_acc) mem_q[wr_ptr_q] <= FIFO_WR_DATA;
  end

  assign FIFO_WR_FULL      = full;
  assign FIFO_WR_ALM_FULL  = (count_q >= alm_thr);
  assign FIFO_RD_ALM_EMPTY = (count_q <= FIFO_RD_ALM_COUNT);
  assign FIFO_RD_EMPTY     = empty;
  assign FIFO_RD_DATA      = rd_data_q;
  assign FIFO_COUNT        = count_q;
  assign FIFO_OVERFLOW     = ovf_q;
  assign FIFO_UNDERFLOW    = unf_q;

endmodule

// File: tb/tb_aq_axi_sdma64_sync_fifo.sv
// Bench for aq_axi_sdma64_sync_fifo: queue-based reference model plus directed literal checks.
module tb_aq_axi_sdma64_sync_fifo;

  localparam int DEP = 9;
  localparam int W   = 65;
  localparam int D   = 1 << DEP;

  logic           CLK = 1'b0;
  logic           RST_N = 1'b1;
  logic           FIFO_CLEAR = 1'b0;
  logic           FIFO_WR_ENA = 1'b0;
  logic [W-1:0]   FIFO_WR_DATA = '0;
  logic           FIFO_WR_FULL;
  logic           FIFO_WR_ALM_FULL;
  logic [DEP:0]   FIFO_WR_ALM_COUNT = 10'd128;
  logic           FIFO_RD_ENA = 1'b0;
  logic [W-1:0]   FIFO_RD_DATA;
  logic           FIFO_RD_EMPTY;
  logic           FIFO_RD_ALM_EMPTY;
  logic [DEP:0]   FIFO_RD_ALM_COUNT = 10'd4;
  logic [DEP:0]   FIFO_COUNT;
  logic           FIFO_OVERFLOW;
  logic           FIFO_UNDERFLOW;

  aq_axi_sdma64_sync_fifo #(.FIFO_DEPTH(DEP), .FIFO_WIDTH(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .FIFO_CLEAR(FIFO_CLEAR),
    .FIFO_WR_ENA(FIFO_WR_ENA), .FIFO_WR_DATA(FIFO_WR_DATA),
    .FIFO_WR_FULL(FIFO_WR_FULL), .FIFO_WR_ALM_FULL(FIFO_WR_ALM_FULL),
    .FIFO_WR_ALM_COUNT(FIFO_WR_ALM_COUNT),
    .FIFO_RD_ENA(FIFO_RD_ENA), .FIFO_RD_DATA(FIFO_RD_DATA),
    .FIFO_RD_EMPTY(FIFO_RD_EMPTY), .FIFO_RD_ALM_EMPTY(FIFO_RD_ALM_EMPTY),
    .FIFO_RD_ALM_COUNT(FIFO_RD_ALM_COUNT), .FIFO_COUNT(FIFO_COUNT),
    .FIFO_OVERFLOW(FIFO_OVERFLOW), .FIFO_UNDERFLOW(FIFO_UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  int ntot = 0;
  int npass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: queue of accepted words, each tagged with the edge that wrote it.
  logic [W-1:0] qd[$];
  int           qt[$];
  int           e = 0;
  logic [W-1:0] last = '0;
  bit           movf = 1'b0;
  bit           munf = 1'b0;

  function automatic bit m_empty();
`ifdef AQ_AXI_SDMA64_SYNC_FIFO_FWFT_EN
    return !(qd.size() > 0 && qt[0] < e);
`else
    return qd.size() == 0;
`endif
  endfunction

  always @(posedge CLK or negedge RST_N) begin : model
    bit emp;
    bit ful;
    if (!RST_N) begin
      qd.delete();
      qt.delete();
      last = '0;
      movf = 1'b0;
      munf = 1'b0;
    end else begin
      emp = m_empty();
      ful = (qd.size() == D);
      e++;
      if (FIFO_CLEAR) begin
        qd.delete();
        qt.delete();
        movf = 1'b0;
        munf = 1'b0;
      end else begin
        if (FIFO_WR_ENA && ful) movf = 1'b1;
        if (FIFO_RD_ENA && emp) munf = 1'b1;
        if (FIFO_RD_ENA && !emp) begin
          last = qd.pop_front();
          void'(qt.pop_front());
        end
        if (FIFO_WR_ENA && !ful) begin
          qd.push_back(FIFO_WR_DATA);
          qt.push_back(e);
        end
      end
    end
  end

  always @(negedge CLK) begin : compare
    int cnt;
    int thr;
    if (chk_en) begin
      cnt = qd.size();
      thr = (D > int'(FIFO_WR_ALM_COUNT)) ? D - int'(FIFO_WR_ALM_COUNT) : 0;
      chk("count", W'(FIFO_COUNT), W'(cnt));
      chk("empty", W'(FIFO_RD_EMPTY), W'(m_empty()));
      chk("full", W'(FIFO_WR_FULL), W'(cnt == D));
      chk("alm_full", W'(FIFO_WR_ALM_FULL), W'(cnt >= thr));
      chk("alm_empty", W'(FIFO_RD_ALM_EMPTY), W'(cnt <= int'(FIFO_RD_ALM_COUNT)));
      chk("overflow", W'(FIFO_OVERFLOW), W'(movf));
      chk("underflow", W'(FIFO_UNDERFLOW), W'(munf));
`ifdef AQ_AXI_SDMA64_SYNC_FIFO_FWFT_EN
      if (!m_empty()) chk("rd_data", FIFO_RD_DATA, qd[0]);
`else
      chk("rd_data", FIFO_RD_DATA, last);
`endif
    end
  end

  task automatic cyc(input bit we, input logic [W-1:0] wd, input bit re, input bit clr);
    FIFO_WR_ENA  = we;
    FIFO_WR_DATA = wd;
    FIFO_RD_ENA  = re;
    FIFO_CLEAR   = clr;
    @(posedge CLK);
    #2;
  endtask

  logic [W-1:0] beef;

  initial begin
    beef = 65'h1_DEAD_BEEF;
    #1 RST_N = 1'b0;
    #1 chk_en = 1'b1;
    chk("rst_count", W'(FIFO_COUNT), '0);
    chk("rst_empty", W'(FIFO_RD_EMPTY), W'(1));
    chk("rst_full", W'(FIFO_WR_FULL), '0);
    chk("rst_ovf", W'(FIFO_OVERFLOW), '0);
    chk("rst_unf", W'(FIFO_UNDERFLOW), '0);
    chk("rst_data", FIFO_RD_DATA, '0);
    chk("rst_alm_empty", W'(FIFO_RD_ALM_EMPTY), W'(1));
    repeat (3) @(posedge CLK);
    #2 RST_N = 1'b1;

    for (int i = 0; i < D; i++) begin
      cyc(1'b1, W'(i), 1'b0, 1'b0);
      if (i == 382) chk("alm_full_383", W'(FIFO_WR_ALM_FULL), '0);
      if (i == 383) chk("alm_full_384", W'(FIFO_WR_ALM_FULL), W'(1));
      if (i == 510) chk("full_511", W'(FIFO_WR_FULL), '0);
    end
    chk("full_512", W'(FIFO_WR_FULL), W'(1));
    cyc(1'b1, W'(999), 1'b0, 1'b0);
    chk("ovf_count", W'(FIFO_COUNT), W'(512));
    chk("ovf_flag", W'(FIFO_OVERFLOW), W'(1));

    for (int i = 0; i < D; i++) begin
`ifdef AQ_AXI_SDMA64_SYNC_FIFO_FWFT_EN
      if (i == 0) chk("first_word", FIFO_RD_DATA, '0);
`endif
      cyc(1'b0, '0, 1'b1, 1'b0);
`ifndef AQ_AXI_SDMA64_SYNC_FIFO_FWFT_EN
      if (i == 0) chk("first_word", FIFO_RD_DATA, '0);
`endif
    end
    chk("drain_count", W'(FIFO_COUNT), '0);
    chk("drain_empty", W'(FIFO_RD_EMPTY), W'(1));
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("unf_flag", W'(FIFO_UNDERFLOW), W'(1));
`ifndef AQ_AXI_SDMA64_SYNC_FIFO_FWFT_EN
    chk("unf_data_hold", FIFO_RD_DATA, W'(511));
`endif
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("clr_ovf", W'(FIFO_OVERFLOW), '0);
    chk("clr_unf", W'(FIFO_UNDERFLOW), '0);

    for (int i = 0; i < 300; i++) cyc(1'b1, W'(1000 + i), 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) cyc(1'b1, W'(2000 + i), 1'b1, 1'b0);
    chk("steady_count", W'(FIFO_COUNT), W'(300));

    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 200; i++) cyc(1'b1, W'(5000 + i), 1'b0, 1'b0);
    chk("pre_clr_count", W'(FIFO_COUNT), W'(200));
    cyc(1'b1, W'(7), 1'b0, 1'b1);
    chk("clr_count", W'(FIFO_COUNT), '0);
    chk("clr_empty", W'(FIFO_RD_EMPTY), W'(1));
    chk("clr_full", W'(FIFO_WR_FULL), '0);
    chk("clr_ovf2", W'(FIFO_OVERFLOW), '0);
    cyc(1'b0, '0, 1'b0, 1'b0);

    cyc(1'b1, beef, 1'b0, 1'b0);
`ifdef AQ_AXI_SDMA64_SYNC_FIFO_FWFT_EN
    chk("beef_empty_n", W'(FIFO_RD_EMPTY), W'(1));
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("beef_empty_n1", W'(FIFO_RD_EMPTY), '0);
    chk("beef_data", FIFO_RD_DATA, beef);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("beef_drained", W'(FIFO_RD_EMPTY), W'(1));
`else
    chk("beef_empty_n", W'(FIFO_RD_EMPTY), '0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("beef_data", FIFO_RD_DATA, beef);
    chk("beef_drained", W'(FIFO_RD_EMPTY), W'(1));
`endif

    for (int i = 0; i < 10; i++) cyc(1'b1, W'(300 + i), 1'b0, 1'b0);
    chk("burst_count", W'(FIFO_COUNT), W'(10));
    #1 RST_N = 1'b0;
    #1;
    chk("arst_count", W'(FIFO_COUNT), '0);
    chk("arst_empty", W'(FIFO_RD_EMPTY), W'(1));
    chk("arst_full", W'(FIFO_WR_FULL), '0);
    chk("arst_ovf", W'(FIFO_OVERFLOW), '0);
    chk("arst_unf", W'(FIFO_UNDERFLOW), '0);
    chk("arst_data", FIFO_RD_DATA, '0);
    FIFO_WR_ENA = 1'b0;
    repeat (2) @(posedge CLK);
    #2 RST_N = 1'b1;
    cyc(1'b1, W'(12'h777), 1'b0, 1'b0);
`ifdef AQ_AXI_SDMA64_SYNC_FIFO_FWFT_EN
    cyc(1'b0, '0, 1'b0, 1'b0);
`else
    cyc(1'b0, '0, 1'b1, 1'b0);
`endif
    chk("post_rst_word", FIFO_RD_DATA, W'(12'h777));
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);

    @(posedge CLK);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/aq_axi_sdma64_sync_fifo.md
AQ_AXI_SDMA64_SYNC_FIFO -- requirements
Module: aq_axi_sdma64_sync_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 9: log2 of storage depth; depth D = 2^FIFO_DEPTH words.
REQ-002 SHALL have parameter FIFO_WIDTH, default 65: data word width in bits.
REQ-003 SHALL have one clock and an asynchronous active-low reset, listed first among the ports below.
REQ-004 CLK  input  1  single clock; all logic on rising edge.
REQ-005 RST_N  input  1  asynchronous active-low reset.
REQ-006 FIFO_CLEAR  input  1  synchronous flush.
REQ-007 FIFO_WR_ENA  input  1  write request.
REQ-008 FIFO_WR_DATA  input  FIFO_WIDTH  write data.
REQ-009 FIFO_WR_FULL  output  1  FIFO_COUNT == D.
REQ-010 FIFO_WR_ALM_FULL  output  1  FIFO_COUNT >= D - FIFO_WR_ALM_COUNT.
REQ-011 FIFO_WR_ALM_COUNT  input  FIFO_DEPTH+1  almost-full offset.
REQ-012 FIFO_RD_ENA  input  1  read request.
REQ-013 FIFO_RD_DATA  output  FIFO_WIDTH  read data.
REQ-014 FIFO_RD_EMPTY  output  1  no word available to read.
REQ-015 FIFO_RD_ALM_EMPTY  output  1  FIFO_COUNT <= FIFO_RD_ALM_COUNT.
REQ-016 FIFO_RD_ALM_COUNT  input  FIFO_DEPTH+1  almost-empty threshold.
REQ-017 FIFO_COUNT  output  FIFO_DEPTH+1  words accepted and not yet read.
REQ-018 FIFO_OVERFLOW  output  1  sticky: write attempted while full.
REQ-019 FIFO_UNDERFLOW  output  1  sticky: read attempted while empty.

Function
REQ-020 Write SHALL be accepted at an edge iff FIFO_WR_ENA=1, FIFO_WR_FULL=0, FIFO_CLEAR=0; a simultaneous read does not free space in that cycle.
REQ-021 Write with FIFO_WR_FULL=1 SHALL be dropped (no pointer/count/data change) and set FIFO_OVERFLOW.
REQ-022 Read SHALL be accepted iff FIFO_RD_ENA=1, FIFO_RD_EMPTY=0, FIFO_CLEAR=0; read while empty SHALL be ignored and set FIFO_UNDERFLOW.
REQ-023 FIFO_COUNT SHALL be registered: +1 on accepted write only, -1 on accepted read only, unchanged on both or neither; never exceeds D, never wraps below 0.
REQ-024 Write/read pointers SHALL be FIFO_DEPTH bits and wrap from D-1 to 0.
REQ-025 FULL, ALM_FULL and ALM_EMPTY SHALL be combinational decodes of registered FIFO_COUNT and threshold inputs; threshold arithmetic SHALL be FIFO_DEPTH+1 bits unsigned, with D - FIFO_WR_ALM_COUNT saturating at 0.
REQ-026 FIFO_CLEAR=1 SHALL, at the edge, zero pointers, FIFO_COUNT, output-valid state and both sticky flags, overriding simultaneous read/write; storage contents are not cleared.
REQ-027 Data SHALL leave in write order with no loss or duplication across pointer wrap.

Reset
REQ-028 RST_N low SHALL immediately force: FIFO_COUNT=0, pointers=0, FIFO_RD_DATA=0, FIFO_RD_EMPTY=1, FIFO_WR_FULL=0, FIFO_OVERFLOW=0, FIFO_UNDERFLOW=0, output stage invalid.
REQ-029 During reset ALM_FULL/ALM_EMPTY SHALL follow REQ-010/REQ-015 with FIFO_COUNT=0.
REQ-030 Reset mid-operation SHALL discard all stored words; first write after release is the first word read.

Configuration
REQ-031 Macro AQ_AXI_SDMA64_SYNC_FIFO_FWFT_EN SHALL select first-word-fall-through.
REQ-032 With macro: output register stage; word written at edge N appears on FIFO_RD_DATA with FIFO_RD_EMPTY=0 after edge N+1 into an empty FIFO; accepted read at edge M presents next word after edge M (or asserts EMPTY); FIFO_COUNT includes the output-stage word; EMPTY is the inverse of output-stage valid.
REQ-033 Without macro: FIFO_RD_EMPTY = (FIFO_COUNT==0); accepted read at edge M loads FIFO_RD_DATA after edge M and holds it until the next accepted read.

Verification
REQ-034 Reset, 9/65: write 512 words 0..511 -> FULL=1 after 512th edge, ALM_FULL=1 at count 384 with WR_ALM_COUNT=128; 513th write -> count stays 512, OVERFLOW=1.
REQ-035 Read all 512 -> data 0..511 in order, EMPTY=1, count 0; one more read -> UNDERFLOW=1, RD_DATA unchanged.
REQ-036 Simultaneous read+write at count 300 for 1000 cycles -> count stays 300, ordering preserved across wrap.
REQ-037 FWFT on: single write 0x1_DEAD_BEEF at edge N into empty -> RD_DATA=0x1_DEAD_BEEF, EMPTY=0 after edge N+1; off: EMPTY=0 after edge N, data after first read.
REQ-038 FIFO_CLEAR with count 200 and WR_ENA=1 -> count 0, EMPTY=1, flags 0; RST_N low mid-burst -> same values immediately, asynchronously.
